// File: rtl/booth_mul_seq.sv
// Signed 32x32->64 radix-4 Booth multiplier sequencer (IDLE -> CALC -> DONE).
// Latency: 16 CALC cycles, out_valid seen 17 cycles after accept; EARLY_TERM_EN cuts CALC short.
// Backpressure: holds product/out_valid in DONE until out_ready; in_ready only in IDLE.

// Shared radix-4 Booth encoder: selects 0, +-A or +-2A as a 33-bit two's complement value.
// -2 * 32'h8000_0000 wraps to 33'h1_0000_0000; the sequencer fixes its extension.
module booth_enc_r4 (
  input  logic [31:0] a,
  input  logic [2:0]  sel,
  output logic [32:0] pp
);

  logic [32:0] a_sx;
  logic [32:0] a_x2;

  // Decode the multiplier triplet into the partial product
  always_comb begin
    a_sx = {a[31], a};
    a_x2 = {a, 1'b0};
    pp   = '0;
    case (sel)
      3'b001, 3'b010: pp = a_sx;
      3'b011:         pp = a_x2;
      3'b100:         pp = -a_x2;
      3'b101, 3'b110: pp = -a_sx;
      default:        pp = '0;
    endcase
  end

endmodule

module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int ITERS = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [32:0] m_q, m_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] product_q, product_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

  logic [2:0]  sel;
  logic [32:0] pp33;
  logic [63:0] pp_ext;
  logic [63:0] pp64;
  logic [63:0] sum;
  logic [32:0] m_sh;
  logic        calc_last;

  booth_enc_r4 u_enc (
    .a   (a_q),
    .sel (sel),
    .pp  (pp33)
  );

  // Datapath: extend and weight this iteration's partial product, add, shift the multiplier
  always_comb begin
    sel = m_q[2:0];
    // -2 * most-negative wraps to 33'h1_0000_0000; it really means +2^32, so zero-extend it
    if (sel == 3'b100 && a_q == 32'h8000_0000) begin
      pp_ext = {31'd0, pp33};
    end else begin
      pp_ext = {{31{pp33[32]}}, pp33};
    end
    pp64 = pp_ext << {cnt_q, 1'b0};
    sum  = acc_q + pp64;
    m_sh = {m_q[32], m_q[32], m_q[32:2]};
`ifdef EARLY_TERM_EN
    // Uniform remaining multiplier bits only produce 000/111 triplets, which add nothing
    calc_last = (cnt_q == 4'(ITERS - 1)) || (&m_sh) || (~|m_sh);
`else
    calc_last = (cnt_q == 4'(ITERS - 1));
`endif
  end

  // Next-state logic for the FSM and every registered output
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = mcand;
          m_d     = {mplier, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = sum;
        m_d   = m_sh;
        cnt_d = cnt_q + 4'd1;
        if (calc_last) begin
          product_d = sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      m_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      m_q         <= m_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule
